// File: rtl/subservient_sram_arbiter.sv
// Round-robin arbiter between two 32-bit Wishbone masters and a byte-wide SRAM.
// Each granted word access is split into four byte beats; read bytes are assembled into rdbuf.
module subservient_sram_arbiter #(
  parameter int depth = 0,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [aw-1:0] i_wb0_adr,
  input  logic [31:0]   i_wb0_dat,
  input  logic [3:0]    i_wb0_sel,
  input  logic          i_wb0_we,
  input  logic          i_wb0_cyc,
  output logic          o_wb0_ack,
  output logic [31:0]   o_wb0_rdt,
  input  logic [aw-1:0] i_wb1_adr,
  input  logic [31:0]   i_wb1_dat,
  input  logic [3:0]    i_wb1_sel,
  input  logic          i_wb1_we,
  input  logic          i_wb1_cyc,
  output logic          o_wb1_ack,
  output logic [31:0]   o_wb1_rdt,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          g_q, g_d;
  logic [aw-3:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [31:0]   rdbuf_q, rdbuf_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;

  logic          ack_set;
  logic [1:0]    cap_idx;
  logic          run;
  logic [aw-1:0] beat_addr;
  logic          unused_adr_lsbs;

  assign unused_adr_lsbs = ^{i_wb0_adr[1:0], i_wb1_adr[1:0]};
  assign cap_idx = cnt_q - 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    g_d     = g_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdbuf_d = rdbuf_q;
    ack_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wb0_cyc || i_wb1_cyc) begin
          // On contention the port that was not served last time wins.
          g_d     = (i_wb0_cyc && i_wb1_cyc) ? ~last_q : i_wb1_cyc;
          adr_d   = g_d ? i_wb1_adr[aw-1:2] : i_wb0_adr[aw-1:2];
          dat_d   = g_d ? i_wb1_dat : i_wb0_dat;
          sel_d   = g_d ? i_wb1_sel : i_wb0_sel;
          we_d    = g_d ? i_wb1_we  : i_wb0_we;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 2'd1;
        if (!we_q && cnt_q != 2'd0) begin
          rdbuf_d[{cap_idx, 3'b000} +: 8] = i_sram_rdata;
        end
        if (cnt_q == 2'd3) begin
          state_d = we_q ? ACK : WAIT;
          ack_set = we_q;
        end
      end
      WAIT: begin
        rdbuf_d[31:24] = i_sram_rdata;
        ack_set        = 1'b1;
        state_d        = ACK;
      end
      default: begin
        last_d  = g_q;
        state_d = IDLE;
      end
    endcase
    ack0_d = ack_set & ~g_d;
    ack1_d = ack_set &  g_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 1'b1;
      g_q     <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdbuf_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      g_q     <= g_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdbuf_q <= rdbuf_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // SRAM strobes are decoded straight from the beat so each byte costs one cycle.
  assign run          = (state_q == RUN);
  assign beat_addr    = {adr_q, cnt_q};
  assign o_sram_waddr = run ? beat_addr : '0;
  assign o_sram_raddr = run ? beat_addr : '0;
  assign o_sram_wen   = run & we_q & sel_q[cnt_q];
  assign o_sram_ren   = run & ~we_q;
  assign o_sram_wdata = (run && we_q) ? dat_q[{cnt_q, 3'b000} +: 8] : 8'h00;

  assign o_wb0_ack = ack0_q;
  assign o_wb1_ack = ack1_q;
  assign o_wb0_rdt = rdbuf_q;
  assign o_wb1_rdt = rdbuf_q;

endmodule

// File: doc/subservient_sram_arbiter.md
# subservient_sram_arbiter

Two-port word-to-byte arbiter and sequencer for the byte-wide single-clock SRAM macro (`subservient_generic_ram`, 8-bit data, 1-cycle registered read). It accepts 32-bit Wishbone-classic-style requests from two masters, for example the CPU data bus and an external loader or debug port. It grants them round-robin and serialises each granted word access into four consecutive byte accesses on the SRAM port, assembling read data before acknowledging.

## Interface
- `depth`, default 0: SRAM depth in bytes; must be a multiple of 4.
- `aw`, default `$clog2(depth)`: byte address width.

- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_wb0_adr`  in  aw  port 0 byte address; bits [1:0] ignored.
- `i_wb0_dat`  in  32  port 0 write data.
- `i_wb0_sel`  in  4  port 0 byte enables; bit n controls byte n, bits [8n+7:8n].
- `i_wb0_we`  in  1  port 0 write (1) / read (0).
- `i_wb0_cyc`  in  1  port 0 request.
- `o_wb0_ack`  out  1  port 0 single-cycle acknowledge.
- `o_wb0_rdt`  out  32  read data; valid when `o_wb0_ack`=1.
- `i_wb1_adr`, `i_wb1_dat`, `i_wb1_sel`, `i_wb1_we`, `i_wb1_cyc`, `o_wb1_ack`, `o_wb1_rdt`: same as port 0, for port 1.
- `o_sram_waddr`  out  aw  SRAM write byte address.
- `o_sram_wdata`  out  8  SRAM write byte.
- `o_sram_wen`  out  1  SRAM write enable.
- `o_sram_raddr`  out  aw  SRAM read byte address.
- `o_sram_ren`  out  1  SRAM read enable.
- `i_sram_rdata`  in  8  SRAM read byte; valid the cycle after `o_sram_ren`.

## Operation
- States: IDLE, RUN, WAIT, ACK. A 2-bit beat counter `cnt` and a `last` grant bit; reset value of `last` is 1.
- IDLE:
  - If any `cyc` is high, latch grant `g`. If only one port requests, that port wins. If both request, `g` = !`last`.
  - Latch that port's adr[aw-1:2], dat, sel and we.
  - Set `cnt`=0 and go to RUN.
- RUN, one byte per cycle, `cnt` = 0..3:
  - Both SRAM addresses = {adr[aw-1:2], cnt}.
  - Write: `o_sram_wen` = sel[cnt] and `o_sram_wdata` = dat[8*cnt+7:8*cnt]. A beat with sel bit 0 still takes its cycle with `wen`=0.
  - Read: `o_sram_ren`=1 on all four beats, regardless of sel.
  - At `cnt`=3, go to WAIT for a read or ACK for a write.
- Read capture: the byte returned in the cycle after beat k is stored into `rdbuf`[8k+7:8k]. Byte 3 is captured in WAIT. WAIT then goes to ACK.
- ACK:
  - Registered `o_wbG_ack`=1 for exactly one cycle; the other port's ack stays 0.
  - Set `last`=`g` and go to IDLE.
- `o_wb0_rdt` and `o_wb1_rdt` are both driven from `rdbuf`.
  - `rdbuf` holds its value between transfers.
  - A write does not modify it.
- Masters must drop `cyc` in the cycle after ack; IDLE samples `cyc` again on the following edge.
- Dropping `cyc` mid-transfer does not abort it. All beats and the ack still occur.
- Inputs of the non-granted port are ignored until the next IDLE.
- Reset, including mid-transfer:
  - The state machine goes immediately to IDLE, with `cnt`=0 and `last`=1.
  - All outputs go to 0: acks, `wen`, `ren`, both addresses, `wdata` and `rdbuf`.
  - No ack is issued for the interrupted transfer. SRAM contents written by earlier beats remain.

## Timing
- Cycle 0 is the IDLE edge that samples `cyc`.
- Write: beats on cycles 1-4, ack on cycle 5, next grant possible on cycle 6, giving 6 cycles per word.
- Read: beats on cycles 1-4, captures on cycles 2-5, ack with valid rdt on cycle 6, giving 7 cycles per word.
- `wen`, `ren` and both addresses are combinational from state, `cnt` and the latched request.
  - They are 0 outside RUN.
  - Addresses read 0 outside RUN.
- Address wrap: the top word {all ones, beats 0..3} stays within `depth`; there is no carry into higher bits.

## Test plan
- Port 0 writes 0xDEADBEEF to adr 0x10 with sel=0xF, then reads it back:
  - SRAM bytes 0x10..0x13 = EF, BE, AD, DE.
  - The write ack comes 5 cycles after the sample edge and the read ack 6 cycles after.
  - rdt = 0xDEADBEEF.
- Port 1 writes 0x11223344 to adr 0x20 with sel=0x5 over prior content 0xAABBCCDD:
  - `wen` is high only on beats 0 and 2.
  - A readback returns 0xAA22CC44.
- Both ports raise `cyc` together on the first cycle after reset, then re-request continuously:
  - Grants alternate 0,1,0,1.
  - Each ack goes only to its own port.
- Port 0 read in progress while port 1 requests at beat 2:
  - Port 0 completes and is acked.
  - Port 1 is granted at the next IDLE.
- Reset asserted at read beat 2:
  - All outputs go to 0 asynchronously.
  - No ack is issued.
  - After release, the first simultaneous request is granted to port 0.
- Read of the top word (adr = depth-4) after writing 0x01020304:
  - Addresses depth-4..depth-1 are used.
  - rdt = 0x01020304.
